seg7_scan_driver: RTL and testbench

Downstream display stage for the modular decimal adder/subtractor. Latches the four-digit BCD result (z3..z0) through a valid/ready handshake. Time-multiplexes it onto a common-segment 7-segment display, one digit per scan slot. New results are applied only at frame boundaries, so the display never shows a mix of old and new digits.

---
 rtl/seg7_pkg.sv | 19 +
 rtl/bcd_to_seg7.sv | 34 +++
 rtl/seg7_scan_driver.sv | 106 ++++++++++
 tb/tb_seg7_scan_driver.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seg7_pkg
// Description : Shared types and constants for the 7-segment scan driver.
// Revision    : 1.0 - initial release
// ============================================================================
package seg7_pkg;

  localparam int NUM_DIGITS = 4;

  typedef logic [3:0] bcd_t;
  typedef logic [6:0] seg_t;

  localparam seg_t SEG_BLANK = 7'b0000000;
  localparam seg_t SEG_DASH  = 7'b1000000;
  localparam seg_t SEG_ZERO  = 7'b0111111;

endpackage
`default_nettype wire

// File: rtl/bcd_to_seg7.sv
`default_nettype none
// ============================================================================
// Module      : bcd_to_seg7
// Description : Combinational BCD nibble to active-high segment pattern
//               (bit order g..a). Non-decimal nibbles render as a dash.
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_to_seg7
  import seg7_pkg::*;
(
  input  bcd_t digit,
  output seg_t pattern
);

  // Standard decimal glyphs; anything above 9 falls back to the dash
  always_comb begin
    pattern = SEG_DASH;
    case (digit)
      4'd0:    pattern = SEG_ZERO;
      4'd1:    pattern = 7'b0000110;
      4'd2:    pattern = 7'b1011011;
      4'd3:    pattern = 7'b1001111;
      4'd4:    pattern = 7'b1100110;
      4'd5:    pattern = 7'b1101101;
      4'd6:    pattern = 7'b1111101;
      4'd7:    pattern = 7'b0000111;
      4'd8:    pattern = 7'b1111111;
      4'd9:    pattern = 7'b1101111;
      default: pattern = SEG_DASH;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/seg7_scan_driver.sv
`default_nettype none
// ============================================================================
// Module      : seg7_scan_driver
// Description : Latches a four-digit BCD result via valid/ready and scans it
//               onto a common-segment 7-segment display, one digit per slot.
//               New results take effect only at frame boundaries.
//               Optional macro LEADING_ZERO_BLANK_EN blanks leading zeros.
// Revision    : 1.0 - initial release
// ============================================================================
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int PRESCALE = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] z,
  output logic [3:0]  an,
  output logic [6:0]  seg
);

  localparam int               CNT_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PRESCALE - 1);

  logic [CNT_W-1:0] cnt;
  logic [1:0]       idx;
  logic [15:0]      shadow;
  logic [15:0]      display;
  logic             pending;

  logic             tick;
  logic             boundary;
  logic             accept;
  bcd_t             cur_digit;
  seg_t             cur_pattern;
  logic             blank;

  assign tick      = (cnt == CNT_LAST);
  assign boundary  = tick && (idx == 2'd3);
  assign in_ready  = !pending;
  assign accept    = in_valid && in_ready;
  assign cur_digit = display[{idx, 2'b00} +: 4];

  bcd_to_seg7 u_dec (
    .digit   (cur_digit),
    .pattern (cur_pattern)
  );

`ifdef LEADING_ZERO_BLANK_EN
  // lead_zero[i]: digits i..3 of the displayed value are all literally zero
  logic [3:0] lead_zero;
  assign lead_zero[3] = (display[15:12] == 4'd0);
  assign lead_zero[2] = (display[11:8]  == 4'd0) && lead_zero[3];
  assign lead_zero[1] = (display[7:4]   == 4'd0) && lead_zero[2];
  assign lead_zero[0] = 1'b0;  // units digit always shown
  assign blank        = lead_zero[idx];
`else
  assign blank = 1'b0;
`endif

  // Prescaler and digit index: advance one slot every PRESCALE cycles
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      idx <= 2'd0;
    end else if (tick) begin
      cnt <= '0;
      idx <= idx + 2'd1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Handshake: capture into shadow, promote to display only at a frame boundary
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow  <= '0;
      display <= '0;
      pending <= 1'b0;
    end else if (boundary && pending) begin
      display <= shadow;
      pending <= 1'b0;
    end else if (accept) begin
      shadow  <= z;
      pending <= 1'b1;
    end
  end

  // Registered digit enable and segment drive for the current slot
  always_ff @(posedge clk) begin
    if (rst) begin
      an  <= 4'b0001;
      seg <= SEG_ZERO;
    end else if (blank) begin
      an  <= 4'b0000;
      seg <= SEG_BLANK;
    end else begin
      an  <= 4'b0001 << idx;
      seg <= cur_pattern;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_driver.sv
`default_nettype none
// ============================================================================
// Module      : tb_seg7_scan_driver
// Description : Self-checking bench for seg7_scan_driver with a reference
//               model of scan position and frame-boundary updates.
//               Honours LEADING_ZERO_BLANK_EN when defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seg7_scan_driver;

  localparam int P = 4;
  localparam logic [6:0] PAT [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                      7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [15:0] z = 16'h0;
  logic        in_ready;
  logic [3:0]  an;
  logic [6:0]  seg;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seg7_scan_driver #(.PRESCALE(P)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .z        (z),
    .an       (an),
    .seg      (seg)
  );

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int dig(input logic [15:0] d, input int pos);
    return int'((d >> (4 * pos)) & 16'hF);
  endfunction

  function automatic bit is_blank(input logic [15:0] d, input int pos);
`ifdef LEADING_ZERO_BLANK_EN
    if (pos == 0) return 1'b0;
    for (int j = pos; j < 4; j++)
      if (dig(d, j) != 0) return 1'b0;
    return 1'b1;
`else
    return (d === 16'hxxxx) && (pos < 0);
`endif
  endfunction

  function automatic logic [6:0] ref_seg(input logic [15:0] d, input int pos);
    int v;
    if (is_blank(d, pos)) return 7'h00;
    v = dig(d, pos);
    if (v > 9) return 7'h40;
    return PAT[v];
  endfunction

  function automatic logic [3:0] ref_an(input logic [15:0] d, input int pos);
    if (is_blank(d, pos)) return 4'b0000;
    return 4'(1 << pos);
  endfunction

  // Model: edges since reset give the scan slot; boundary every 4*P edges
  int          m_k;
  logic [15:0] m_shadow, m_disp;
  logic        m_pend;
  logic [3:0]  exp_an;
  logic [6:0]  exp_seg;
  bit          m_valid = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_k      <= 0;
      m_shadow <= 16'h0;
      m_disp   <= 16'h0;
      m_pend   <= 1'b0;
      exp_an   <= 4'b0001;
      exp_seg  <= 7'h3F;
      m_valid  <= 1'b1;
    end else begin
      m_k     <= m_k + 1;
      exp_an  <= ref_an(m_disp, (m_k / P) % 4);
      exp_seg <= ref_seg(m_disp, (m_k / P) % 4);
      if (((m_k + 1) % (4 * P) == 0) && m_pend) begin
        m_disp <= m_shadow;
        m_pend <= 1'b0;
      end else if (in_valid && !m_pend) begin
        m_shadow <= z;
        m_pend   <= 1'b1;
      end
    end
  end

  // Continuous comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (m_valid) begin
      check_eq("an", 16'(an), 16'(exp_an));
      check_eq("seg", 16'(seg), 16'(exp_seg));
      check_eq("in_ready", 16'(in_ready), 16'(!m_pend));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send(input logic [15:0] v);
    @(negedge clk);
    in_valid = 1'b1;
    z        = v;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!in_ready && n < 5 * P + 2) begin
      @(negedge clk);
      n++;
    end
    check_eq("ready_rise", 16'(in_ready), 16'd1);
  endtask

  // After the applying boundary, step through all four slots of value v
  task automatic check_frame(input string tag, input logic [15:0] v);
    wait_ready();
    @(negedge clk);
    for (int s = 0; s < 4; s++) begin
      if (s > 0) repeat (P) @(negedge clk);
      check_eq({tag, "_an"}, 16'(an), 16'(ref_an(v, s)));
      check_eq({tag, "_seg"}, 16'(seg), 16'(ref_seg(v, s)));
    end
  endtask

  initial begin
    int hits;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Reset state and slot rotation
    check_eq("rst_an", 16'(an), 16'h1);
    check_eq("rst_seg", 16'(seg), 16'h3F);
    check_eq("rst_ready", 16'(in_ready), 16'h1);
    @(negedge clk);
    for (int s = 1; s < 4; s++) begin
      repeat (P) @(negedge clk);
      check_eq("rotate_an", 16'(an), 16'(ref_an(16'h0, s)));
    end

    // Accept and display
    wait_ready();
    send(16'h1234);
    check_eq("busy_1234", 16'(in_ready), 16'h0);
    check_frame("d1234", 16'h1234);

    // Back-pressure: 9999 held while 0001 is pending
    wait_ready();
    @(negedge clk);
    in_valid = 1'b1;
    z        = 16'h0001;
    @(negedge clk);
    z        = 16'h9999;
    check_eq("bp_busy", 16'(in_ready), 16'h0);
    wait_ready();
    @(negedge clk);
    check_eq("bp_first_seg", 16'(seg), 16'(ref_seg(16'h0001, 0)));
    check_eq("bp_accept", 16'(in_ready), 16'h0);
    in_valid = 1'b0;
    check_frame("d9999", 16'h9999);

    // Invalid BCD nibble
    wait_ready();
    send(16'h00A5);
    check_frame("d00A5", 16'h00A5);

    // Leading zeros
    wait_ready();
    send(16'h0007);
    check_frame("d0007", 16'h0007);

    // Reset mid-operation discards the pending result
    wait_ready();
    send(16'h4321);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check_eq("mid_rst_an", 16'(an), 16'h1);
    check_eq("mid_rst_seg", 16'(seg), 16'h3F);
    check_eq("mid_rst_ready", 16'(in_ready), 16'h1);
    hits = 0;
    repeat (8 * P + 2) begin
      @(negedge clk);
      if (an == 4'b0001 && seg == 7'h06) hits++;
    end
    check_eq("no_4321", 16'(hits), 16'h0);

    // Randomized traffic with occasional resets
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      rst      = ($urandom_range(0, 299) == 0);
      in_valid = ($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 2))
        0: z = 16'($urandom);
        1: for (int j = 0; j < 4; j++) z[4*j +: 4] = 4'($urandom_range(0, 9));
        default: z = {12'h000, 4'($urandom_range(0, 15))};
      endcase
    end
    rst      = 1'b0;
    in_valid = 1'b0;
    repeat (4) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
